// File: rtl/bpf2_spi_tx.sv
// Serialises {ctrl, BPF2} to the filter-board shift register, then pulses latch enable.
// Optional macro BPF2_ONEHOT_CHECK_EN substitutes LPF bypass for an invalid select and flags a sticky fault.
module bpf2_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] BPF2,
  input  logic [7:0] ctrl,
  output logic       spi_clk,
  output logic       spi_data,
  output logic       spi_le,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic [15:0] last_sent;
  logic        pending;
  logic [15:0] raw_word;
  logic [15:0] sel_word;
  logic        start_frame;

  assign raw_word    = {ctrl, BPF2};
  assign start_frame = (state == IDLE) && (pending || (raw_word != last_sent));

`ifdef BPF2_ONEHOT_CHECK_EN
  logic bpf_valid;

  assign bpf_valid = (BPF2 != 8'h00) && ((BPF2 & (BPF2 - 8'd1)) == 8'h00);
  assign sel_word  = bpf_valid ? raw_word : {ctrl, 8'h01};

  always_ff @(posedge clock) begin
    if (reset)
      fault <= 1'b0;
    else if (start_frame && !bpf_valid)
      fault <= 1'b1;
  end
`else
  assign sel_word = raw_word;
  assign fault    = 1'b0;
`endif

  // last_sent holds the raw input word so an invalid select is not resent forever
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      spi_clk   <= 1'b0;
      spi_data  <= 1'b0;
      spi_le    <= 1'b0;
      busy      <= 1'b0;
      div_cnt   <= 8'd0;
      bit_cnt   <= 5'd0;
      shift_reg <= 16'h0000;
      last_sent <= 16'h0000;
      pending   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          spi_clk  <= 1'b0;
          spi_data <= 1'b0;
          spi_le   <= 1'b0;
          busy     <= 1'b0;
          if (start_frame) begin
            shift_reg <= sel_word;
            last_sent <= raw_word;
            pending   <= 1'b0;
            spi_data  <= sel_word[15];
            busy      <= 1'b1;
            div_cnt   <= 8'd0;
            bit_cnt   <= 5'd0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
            end else begin
              spi_clk <= 1'b0;
              if (bit_cnt == 5'd15) begin
                spi_le   <= 1'b1;
                spi_data <= 1'b0;
                state    <= LATCH;
              end else begin
                bit_cnt   <= bit_cnt + 5'd1;
                shift_reg <= {shift_reg[14:0], 1'b0};
                spi_data  <= shift_reg[14];
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        LATCH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            spi_le  <= 1'b0;
            state   <= GAP;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        GAP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpf2_spi_tx.sv
// Randomised self-checking bench for bpf2_spi_tx; a passive monitor decodes frames from the pins.
// Honours BPF2_ONEHOT_CHECK_EN for the expected low byte and fault behaviour.
`timescale 1ns/1ps
module tb_bpf2_spi_tx;

  localparam int DIV       = 4;
  localparam int FRAME_LEN = 34 * DIV;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] BPF2;
  logic [7:0] ctrl;
  logic       spi_clk, spi_data, spi_le, busy, fault;

  int n_compared   = 0;
  int n_mismatched = 0;

  bpf2_spi_tx #(.CLK_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .BPF2(BPF2), .ctrl(ctrl),
    .spi_clk(spi_clk), .spi_data(spi_data), .spi_le(spi_le),
    .busy(busy), .fault(fault)
  );

  always #5 clock = ~clock;

  // Pin-level monitor: rebuilds each frame from spi_clk rising edges and measures pulse widths
  int          le_count = 0;
  logic [15:0] word_q[$];
  int          rise_q[$];
  int          le_len_q[$];
  int          busy_len_q[$];
  logic [15:0] acc = 16'h0;
  int          rises = 0, le_run = 0, busy_run = 0;
  logic        prev_clk = 1'b0, prev_le = 1'b0, prev_busy = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      acc = 16'h0; rises = 0; le_run = 0; busy_run = 0;
    end else begin
      if (spi_clk && !prev_clk) begin
        acc = {acc[14:0], spi_data};
        rises++;
      end
      if (spi_le && !prev_le) begin
        word_q.push_back(acc);
        rise_q.push_back(rises);
        rises = 0;
        le_count++;
      end
      if (spi_le) le_run++;
      else if (prev_le) begin le_len_q.push_back(le_run); le_run = 0; end
      if (busy) busy_run++;
      else if (prev_busy) begin busy_len_q.push_back(busy_run); busy_run = 0; end
    end
    prev_clk  = spi_clk;
    prev_le   = spi_le;
    prev_busy = busy;
  end

  // Reference: the word a frame should carry for a given input snapshot
  function automatic logic [15:0] expected_frame(input logic [7:0] c, input logic [7:0] b);
`ifdef BPF2_ONEHOT_CHECK_EN
    if ($countones(b) != 1) return {c, 8'h01};
`endif
    return {c, b};
  endfunction

  function automatic logic expected_fault(input logic [7:0] b);
`ifdef BPF2_ONEHOT_CHECK_EN
    return $countones(b) != 1;
`else
    return 1'b0 && (b == 8'h00);
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while ((le_count < target || busy) && c < budget) begin
      tick(1);
      c++;
    end
    if (c >= budget) begin
      n_compared++; n_mismatched++;
      $display("[TB] FAIL wait_done: timeout, le_count=%0d required %0d", le_count, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; BPF2 = 8'h01; ctrl = 8'h00;
    tick(3);
    n_compared++;
    if ({spi_clk, spi_data, spi_le, busy, fault} !== 5'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got %b required 00000", {spi_clk, spi_data, spi_le, busy, fault});
    end
  endtask

  task automatic test_first_frame();
    int base = le_count;
    int lb = le_len_q.size();
    int bb = busy_len_q.size();
    reset = 1'b0;
    tick(1);
    n_compared++;
    if ({busy, spi_data} !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL first_latency: busy/data %b required 10", {busy, spi_data});
    end
    wait_done(base + 1, 400);
    if (word_q.size() > base && le_len_q.size() > lb && busy_len_q.size() > bb) begin
      n_compared++;
      if (word_q[base] !== 16'h0001) begin
        n_mismatched++;
        $display("[TB] FAIL first_word: got %h required 0001", word_q[base]);
      end
      n_compared++;
      if (le_len_q[lb] != DIV) begin
        n_mismatched++;
        $display("[TB] FAIL first_le_len: got %0d required %0d", le_len_q[lb], DIV);
      end
      n_compared++;
      if (busy_len_q[bb] != FRAME_LEN) begin
        n_mismatched++;
        $display("[TB] FAIL first_busy_len: got %0d required %0d", busy_len_q[bb], FRAME_LEN);
      end
    end
    tick(300);
    n_compared++;
    if (le_count != base + 1) begin
      n_mismatched++;
      $display("[TB] FAIL first_no_extra: frames %0d required %0d", le_count - base, 1);
    end
  endtask

  task automatic test_frames();
    for (int i = 0; i < 7; i++) begin
      logic [7:0]  c, b;
      logic [15:0] exp_w;
      int base = le_count;
      int bb;
      if (i == 0) begin c = 8'hA5; b = 8'h20; end
      else begin
        c = 8'($urandom);
        b = 8'h01 << $urandom_range(7, 0);
        if ({c, b} == {ctrl, BPF2}) c = c ^ 8'h01;
      end
      exp_w = expected_frame(c, b);
      ctrl = c; BPF2 = b;
      bb = busy_len_q.size();
      tick(1);
      n_compared++;
      if ({busy, spi_data} !== {1'b1, exp_w[15]}) begin
        n_mismatched++;
        $display("[TB] FAIL frame%0d_latency: busy/data %b required %b", i, {busy, spi_data}, {1'b1, exp_w[15]});
      end
      wait_done(base + 1, 400);
      if (word_q.size() > base && busy_len_q.size() > bb) begin
        n_compared++;
        if (word_q[base] !== exp_w || rise_q[base] != 16) begin
          n_mismatched++;
          $display("[TB] FAIL frame%0d_word: got %h/%0d rises required %h/16", i, word_q[base], rise_q[base], exp_w);
        end
        n_compared++;
        if (busy_len_q[bb] != FRAME_LEN) begin
          n_mismatched++;
          $display("[TB] FAIL frame%0d_busy_len: got %0d required %0d", i, busy_len_q[bb], FRAME_LEN);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base = le_count;
    logic [7:0] c = ctrl ^ 8'hFF;
    ctrl = c; BPF2 = 8'h04;
    tick(1);
    tick(9);
    BPF2 = 8'h08;
    tick(40);
    BPF2 = 8'h10;
    wait_done(base + 2, 800);
    if (word_q.size() > base + 1) begin
      n_compared++;
      if (word_q[base] !== expected_frame(c, 8'h04)) begin
        n_mismatched++;
        $display("[TB] FAIL collapse_first: got %h required %h", word_q[base], expected_frame(c, 8'h04));
      end
      n_compared++;
      if (word_q[base + 1] !== expected_frame(c, 8'h10)) begin
        n_mismatched++;
        $display("[TB] FAIL collapse_follow: got %h required %h", word_q[base + 1], expected_frame(c, 8'h10));
      end
    end
    tick(300);
    n_compared++;
    if (le_count != base + 2) begin
      n_mismatched++;
      $display("[TB] FAIL collapse_count: frames %0d required 2", le_count - base);
    end
  endtask

  task automatic test_reset_mid();
    int base = le_count;
    int bb;
    logic [7:0] c = ctrl ^ 8'hFF;
    logic [7:0] b = 8'h01 << $urandom_range(7, 0);
    ctrl = c; BPF2 = b;
    tick(1);
    tick(69);
    reset = 1'b1;
    tick(1);
    n_compared++;
    if ({spi_clk, spi_data, spi_le, busy} !== 4'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_outputs: got %b required 0000", {spi_clk, spi_data, spi_le, busy});
    end
    n_compared++;
    if (le_count != base) begin
      n_mismatched++;
      $display("[TB] FAIL abort_no_le: le pulses %0d required 0", le_count - base);
    end
    tick(2);
    bb = busy_len_q.size();
    reset = 1'b0;
    wait_done(base + 1, 400);
    if (word_q.size() > base && busy_len_q.size() > bb) begin
      n_compared++;
      if (word_q[base] !== expected_frame(c, b) || busy_len_q[bb] != FRAME_LEN) begin
        n_mismatched++;
        $display("[TB] FAIL restart_frame: got %h/%0d required %h/%0d", word_q[base], busy_len_q[bb], expected_frame(c, b), FRAME_LEN);
      end
    end
  endtask

  task automatic test_onehot();
    int base = le_count;
    logic [7:0] c = ctrl ^ 8'hFF;
    ctrl = c; BPF2 = 8'h06;
    wait_done(base + 1, 400);
    if (word_q.size() > base) begin
      n_compared++;
      if (word_q[base] !== expected_frame(c, 8'h06)) begin
        n_mismatched++;
        $display("[TB] FAIL onehot_word: got %h required %h", word_q[base], expected_frame(c, 8'h06));
      end
    end
    n_compared++;
    if (fault !== expected_fault(8'h06)) begin
      n_mismatched++;
      $display("[TB] FAIL onehot_fault: got %b required %b", fault, expected_fault(8'h06));
    end
    BPF2 = 8'h02;
    wait_done(base + 2, 400);
    n_compared++;
    if (fault !== expected_fault(8'h06)) begin
      n_mismatched++;
      $display("[TB] FAIL fault_sticky: got %b required %b", fault, expected_fault(8'h06));
    end
    reset = 1'b1;
    tick(2);
    n_compared++;
    if (fault !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL fault_reset: got %b required 0", fault);
    end
    reset = 1'b0;
    wait_done(base + 3, 400);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_frames();
    test_back_to_back();
    test_reset_mid();
    test_onehot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bpf2_spi_tx.md
BPF2_SPI_TX -- requirements
Module: bpf2_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, sets the SCLK half-period in clock cycles; legal range is 2..255.
REQ-002 Port clock, input, 1 bit, is the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port reset, input, 1 bit, is a synchronous, active-high reset.
REQ-004 Port BPF2, input, 8 bits, carries the one-hot RX BPF select word from the band decoder.
REQ-005 Port ctrl, input, 8 bits, carries the auxiliary relay bits (attenuator/preamp) sent in the same frame.
REQ-006 Port spi_clk, output, 1 bit, is the serial clock to the filter-board shift register.
REQ-007 Port spi_data, output, 1 bit, is the serial data line, MSB first.
REQ-008 Port spi_le, output, 1 bit, is the latch-enable strobe, active high.
REQ-009 Port busy, output, 1 bit, is high from frame start until the end of the GAP state.
REQ-010 Port fault, output, 1 bit, is the sticky invalid-select flag (see Configuration).

Function
REQ-011 The frame SHALL be 16 bits, {ctrl[7:0], BPF2[7:0]}, transmitted with bit 15 first.
REQ-012 The FSM SHALL have four states: IDLE, SHIFT, LATCH and GAP.
REQ-013 In IDLE, a frame SHALL start when the pending flag is set or when {ctrl,BPF2} differs from the last-sent word.
- On start, the word is snapshotted into the shift register and the last-sent register.
- The pending flag is cleared.
REQ-014 Start latency: if the start condition is true at rising edge N, spi_data SHALL carry bit 15 and busy SHALL be high from edge N+1.
REQ-015 Each bit in SHIFT SHALL last 2*CLK_DIV cycles.
- spi_clk is low for the first CLK_DIV cycles and high for the next CLK_DIV cycles.
- spi_data changes only while spi_clk is low, at the start of the bit period.
REQ-016 After the 16th high phase, the FSM SHALL enter LATCH.
- In LATCH, spi_clk=0 and spi_le=1 for CLK_DIV cycles.
REQ-017 The FSM SHALL then enter GAP.
- In GAP, spi_le=0, spi_clk=0 and spi_data=0 for CLK_DIV cycles.
- On exit from GAP, busy falls and the FSM returns to IDLE.
REQ-018 Total frame length SHALL be 34*CLK_DIV cycles.
REQ-019 Input changes during a frame SHALL NOT alter that frame.
- The change is detected in IDLE against the last-sent word, producing exactly one follow-up frame carrying the most recent value.
- Multiple changes during one frame SHALL collapse into that single follow-up frame.
REQ-020 Bit counter and divider counter widths SHALL be 5 bits and 8 bits respectively; no wrap-around SHALL occur within legal CLK_DIV.
REQ-021 In IDLE, spi_clk, spi_data and spi_le SHALL all be 0.

Reset
REQ-022 Reset SHALL force the FSM to IDLE and set spi_clk=0, spi_data=0, spi_le=0, busy=0 and fault=0.
REQ-023 Reset SHALL clear the last-sent register to 16'h0000 and set the pending flag, so that exactly one frame is sent after reset release.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no spi_le pulse; the full frame SHALL restart after release.

Configuration
REQ-025 Macro BPF2_ONEHOT_CHECK_EN controls one-hot checking of the BPF2 snapshot.
- Defined: at snapshot time, if BPF2 is not exactly one-hot, the frame SHALL carry 8'b00000001 (LPF bypass) in bits 7:0 and fault SHALL set and stay set until reset.
- Undefined: BPF2 is sent unmodified and fault SHALL be tied to 0.

Verification
REQ-026 Release reset with BPF2=8'h01, ctrl=8'h00, CLK_DIV=4 -> one frame of 136 cycles shifting 16'h0001, one spi_le pulse of 4 cycles, busy high for 136 cycles, then idle with no further frames.
REQ-027 Change BPF2 to 8'h20 and ctrl to 8'hA5 while idle -> spi_data samples on rising spi_clk read 16'hA520, MSB first, with 16 rising edges before spi_le rises.
REQ-028 Change BPF2 8'h04 -> 8'h08 -> 8'h10 during frame cycles 10 and 50 -> the current frame completes unchanged, then exactly one follow-up frame carries 8'h10.
REQ-029 Assert reset at frame cycle 70 -> outputs are 0 on the next cycle with no spi_le pulse; after release, a complete frame of the current inputs is sent.
REQ-030 With BPF2_ONEHOT_CHECK_EN defined, apply BPF2=8'h06 -> frame bits 7:0 = 8'h01 and fault=1 persists until reset; without the macro -> frame bits 7:0 = 8'h06 and fault=0.
